// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits, optional parity and 1/2 stop bits.
// A one-entry holding register lets the next frame start directly after the last stop bit.
module uart_tx_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pulse,
  input  logic [DATA_BITS-1:0] character,
  input  logic                 start,
  output logic                 ready,
  output logic                 signal,
  output logic                 busy,
  output logic                 done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 parity_q, parity_d;
  logic                 signal_q, signal_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      parity_q     <= 1'b0;
      signal_q     <= 1'b1;
      done_q       <= 1'b0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      parity_q     <= parity_d;
      signal_q     <= signal_d;
      done_q       <= done_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    hold_valid_d = hold_valid_q;
    parity_d     = parity_q;
    signal_d     = signal_q;
    done_d       = 1'b0;
    bit_idx_d    = bit_idx_q;
    stop_cnt_d   = stop_cnt_q;

    if (start && !hold_valid_q) begin
      hold_d       = character;
      hold_valid_d = 1'b1;
    end

    if (pulse) begin
      case (state_q)
        S_IDLE: begin
          signal_d = 1'b1;
          if (hold_valid_q) begin
            shift_d      = hold_q;
            parity_d     = (PARITY == 1) ? ~^hold_q : ^hold_q;
            hold_valid_d = 1'b0;
            signal_d     = 1'b0;
            state_d      = S_START;
          end
        end
        S_START: begin
          signal_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY != 0) begin
              signal_d = parity_q;
              state_d  = S_PARITY;
            end else begin
              signal_d   = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            signal_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
        S_PARITY: begin
          signal_d   = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
        S_STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            // A waiting character goes straight into its start bit, no idle period.
            if (hold_valid_q) begin
              shift_d      = hold_q;
              parity_d     = (PARITY == 1) ? ~^hold_q : ^hold_q;
              hold_valid_d = 1'b0;
              signal_d     = 1'b0;
              state_d      = S_START;
            end else begin
              signal_d = 1'b1;
              state_d  = S_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          signal_d = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  assign ready  = ~hold_valid_q;
  assign signal = signal_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameter sets (8N1, 8E1, 8O1, 7N2) driven from a vector table
// plus hand-written back-to-back, mid-frame reset and pulse/start coincidence sequences.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic       pulse;
  logic [7:0] char_v;
  logic [3:0] start_v;
  logic       ready_w [4];
  logic       sig_w   [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int sel;
  int done_cnt;
  int checks;
  int errors;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .pulse(pulse), .character(char_v), .start(start_v[0]),
    .ready(ready_w[0]), .signal(sig_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .pulse(pulse), .character(char_v), .start(start_v[1]),
    .ready(ready_w[1]), .signal(sig_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .pulse(pulse), .character(char_v), .start(start_v[2]),
    .ready(ready_w[2]), .signal(sig_w[2]), .busy(busy_w[2]), .done(done_w[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .pulse(pulse), .character(char_v[6:0]), .start(start_v[3]),
    .ready(ready_w[3]), .signal(sig_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [7:0]  ch;
    int          len;
    logic [0:11] seq;  // line level per bit period, leftmost first
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p);
    pulse = p;
    @(posedge clk);
    #1;
    pulse = 1'b0;
    if (done_w[sel]) done_cnt++;
  endtask

  task automatic baud();
    step(1'b0);
    step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_v = '0;
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    done_cnt = 0;
  endtask

  task automatic accept(input int s, input logic [7:0] c);
    char_v     = c;
    start_v[s] = 1'b1;
    step(1'b0);
    start_v[s] = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [0:11] seq, input int len);
    for (int k = 0; k < len; k++) begin
      baud();
      chk({tag, " signal"}, 32'(sig_w[sel]), 32'(seq[k]));
      chk({tag, " busy"}, 32'(busy_w[sel]), 32'd1);
      if (k == 0) chk({tag, " ready after load"}, 32'(ready_w[sel]), 32'd1);
    end
    chk({tag, " no early done"}, 32'(done_cnt), 32'd0);
    baud();
    chk({tag, " done at last stop"}, 32'(done_w[sel]), 32'd1);
    chk({tag, " done count"}, 32'(done_cnt), 32'd1);
    chk({tag, " idle line"}, 32'(sig_w[sel]), 32'd1);
    chk({tag, " idle busy"}, 32'(busy_w[sel]), 32'd0);
  endtask

  initial begin
    logic [0:19] b2b;
    logic        line_ok;

    checks   = 0;
    errors   = 0;
    sel      = 0;
    done_cnt = 0;
    rst      = 1'b0;
    pulse    = 1'b0;
    char_v   = '0;
    start_v  = '0;

    vecs[0] = '{0, 8'h64, 10, 12'b0_00100110_1_11};
    vecs[1] = '{0, 8'hA5, 10, 12'b0_10100101_1_11};
    vecs[2] = '{1, 8'h64, 11, 12'b0_00100110_1_1_1};
    vecs[3] = '{1, 8'hFF, 11, 12'b0_11111111_0_1_1};
    vecs[4] = '{2, 8'h64, 11, 12'b0_00100110_0_1_1};
    vecs[5] = '{2, 8'h00, 11, 12'b0_00000000_1_1_1};
    vecs[6] = '{3, 8'h55, 10, 12'b0_1010101_11_11};
    vecs[7] = '{3, 8'h01, 10, 12'b0_1000000_11_11};

    do_reset();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset signal dut%0d", d), 32'(sig_w[d]), 32'd1);
      chk($sformatf("reset busy dut%0d", d), 32'(busy_w[d]), 32'd0);
      chk($sformatf("reset ready dut%0d", d), 32'(ready_w[d]), 32'd1);
      chk($sformatf("reset done dut%0d", d), 32'(done_w[d]), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_reset();
      sel = vecs[i].sel;
      accept(vecs[i].sel, vecs[i].ch);
      chk($sformatf("vec%0d ready after accept", i), 32'(ready_w[sel]), 32'd0);
      chk($sformatf("vec%0d line before pulse", i), 32'(sig_w[sel]), 32'd1);
      expect_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].len);
      $display("frame vec%0d dut%0d char=%02h len=%0d done", i, vecs[i].sel, vecs[i].ch, vecs[i].len);
    end

    // Back-to-back: A5 then 3C queued mid-frame; a third start while full is dropped.
    do_reset();
    sel = 0;
    b2b = 20'b0_10100101_1_0_00111100_1;
    accept(0, 8'hA5);
    for (int k = 0; k < 23; k++) begin
      baud();
      chk($sformatf("b2b signal k%0d", k), 32'(sig_w[0]), (k < 20) ? 32'(b2b[k]) : 32'd1);
      chk($sformatf("b2b done k%0d", k), 32'(done_w[0]), (k == 10 || k == 20) ? 32'd1 : 32'd0);
      chk($sformatf("b2b busy k%0d", k), 32'(busy_w[0]), (k < 20) ? 32'd1 : 32'd0);
      if (k == 3) begin
        chk("b2b ready mid-frame", 32'(ready_w[0]), 32'd1);
        accept(0, 8'h3C);
        chk("b2b ready after queue", 32'(ready_w[0]), 32'd0);
        accept(0, 8'hFF);
        chk("b2b ready after ignored start", 32'(ready_w[0]), 32'd0);
      end
    end
    chk("b2b done total", 32'(done_cnt), 32'd2);
    $display("back-to-back A5,3C sent, done pulses=%0d", done_cnt);

    // Reset during data bit 4 with a second byte held.
    do_reset();
    sel = 0;
    accept(0, 8'h64);
    for (int k = 0; k < 6; k++) baud();
    accept(0, 8'hFF);
    chk("rst hold full", 32'(ready_w[0]), 32'd0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    chk("rst signal", 32'(sig_w[0]), 32'd1);
    chk("rst busy", 32'(busy_w[0]), 32'd0);
    chk("rst ready", 32'(ready_w[0]), 32'd1);
    chk("rst done", 32'(done_w[0]), 32'd0);
    line_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      baud();
      if (sig_w[0] !== 1'b1 || busy_w[0] !== 1'b0) line_ok = 1'b0;
    end
    chk("rst held byte discarded", 32'(line_ok), 32'd1);
    chk("rst no done", 32'(done_cnt), 32'd0);
    accept(0, 8'hA5);
    expect_frame("post-rst", 12'b0_10100101_1_11, 10);
    $display("mid-frame reset handled, clean A5 frame after");

    // start coincident with pulse in IDLE: start bit waits for the next pulse.
    do_reset();
    sel        = 0;
    char_v     = 8'h64;
    start_v[0] = 1'b1;
    step(1'b1);
    start_v[0] = 1'b0;
    chk("coinc line still idle", 32'(sig_w[0]), 32'd1);
    chk("coinc busy", 32'(busy_w[0]), 32'd0);
    chk("coinc ready", 32'(ready_w[0]), 32'd0);
    baud();
    chk("coinc start bit", 32'(sig_w[0]), 32'd0);
    chk("coinc busy next", 32'(busy_w[0]), 32'd1);
    $display("coincident start/pulse delayed to next tick");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
